// File: rtl/spi_slave_framer.sv
// SPI slave that splits each chip-select frame into command, address and data fields.
// It can also shift a response word out on MISO during the data field.
module spi_slave_framer #(
  parameter int CMD_BYTES   = 2,
  parameter int ADDR_BYTES  = 1,
  parameter int DATA_BYTES  = 5,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    spi_clk,
  input  logic                    spi_mosi,
  input  logic                    spi_scsn,
  output logic                    spi_miso,
  output logic [CMD_BYTES*8-1:0]  spi_cmd_r,
  output logic                    spi_cmd_valid_r,
  output logic [ADDR_BYTES*8-1:0] spi_addr_r,
  output logic                    spi_addr_valid_r,
  output logic [DATA_BYTES*8-1:0] spi_data_r,
  output logic                    spi_data_valid_r,
  input  logic [DATA_BYTES*8-1:0] spi_sdo,
  input  logic                    spi_sdo_valid,
  output logic                    spi_done,
  output logic                    spi_frame_err
);

  localparam int CMD_BITS  = CMD_BYTES * 8;
  localparam int ADDR_BITS = ADDR_BYTES * 8;
  localparam int DATA_BITS = DATA_BYTES * 8;
  localparam int SHW_CA    = (CMD_BITS > ADDR_BITS) ? CMD_BITS : ADDR_BITS;
  localparam int SHW       = (DATA_BITS > SHW_CA) ? DATA_BITS : SHW_CA;

  localparam logic       CLK_IDLE    = (CPOL != 0);
  localparam logic       SAMPLE_RISE = (CPOL == CPHA);
  localparam logic       LATE_PHASE  = (CPHA != 0);
  localparam logic [2:0] PRIME_N     = 3'(SYNC_STAGES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_TAIL
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic [SYNC_STAGES-1:0] r_scsnSync;
  logic                   r_sclkD;
  logic                   r_scsnD;
  logic [2:0]             r_primeCnt;
  logic                   r_armed;

  logic [6:0]           r_bitCnt;
  logic [SHW-2:0]       r_shift;
  logic [CMD_BITS-1:0]  r_cmd;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_cmdValid;
  logic                 r_addrValid;
  logic                 r_dataValid;
  logic                 r_done;
  logic                 r_err;
  logic                 r_donePend;
  logic [DATA_BITS-1:0] r_tx;
  logic                 r_txLoaded;
  logic                 r_txStarted;

  logic           w_sclk;
  logic           w_mosi;
  logic           w_scsn;
  logic           w_sclkRise;
  logic           w_sclkFall;
  logic           w_sampleEv;
  logic           w_launchEv;
  logic           w_csFall;
  logic           w_csRise;
  logic           w_lastBit;
  logic           w_fieldDone;
  logic           w_inField;
  logic [SHW-1:0] w_shiftNext;

  assign w_sclk      = r_sclkSync[SYNC_STAGES-1];
  assign w_mosi      = r_mosiSync[SYNC_STAGES-1];
  assign w_scsn      = r_scsnSync[SYNC_STAGES-1];
  assign w_sclkRise  = w_sclk & ~r_sclkD;
  assign w_sclkFall  = ~w_sclk & r_sclkD;
  assign w_sampleEv  = SAMPLE_RISE ? w_sclkRise : w_sclkFall;
  assign w_launchEv  = SAMPLE_RISE ? w_sclkFall : w_sclkRise;
  assign w_csFall    = ~w_scsn & r_scsnD & r_armed;
  assign w_csRise    = w_scsn & ~r_scsnD;
  assign w_fieldDone = w_sampleEv & w_lastBit;
  assign w_inField   = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_shiftNext = {r_shift, w_mosi};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sclkSync <= {SYNC_STAGES{CLK_IDLE}};
      r_mosiSync <= '1;
      r_scsnSync <= '1;
      r_sclkD    <= CLK_IDLE;
      r_scsnD    <= 1'b1;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], spi_clk};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi_mosi};
      r_scsnSync <= {r_scsnSync[SYNC_STAGES-2:0], spi_scsn};
      r_sclkD    <= w_sclk;
      r_scsnD    <= w_scsn;
    end
  end

  // Chip select must be seen high on real (flushed) synchroniser data before a frame may start,
  // so a select held low across reset cannot fake a falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_primeCnt <= '0;
      r_armed    <= 1'b0;
    end else if (r_primeCnt != PRIME_N) begin
      r_primeCnt <= r_primeCnt + 3'd1;
    end else if (w_scsn && r_scsnD) begin
      r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_lastBit = 1'b0;
    case (r_state)
      S_CMD:   w_lastBit = (r_bitCnt == 7'(CMD_BITS - 1));
      S_ADDR:  w_lastBit = (r_bitCnt == 7'(ADDR_BITS - 1));
      S_DATA:  w_lastBit = (r_bitCnt == 7'(DATA_BITS - 1));
      default: w_lastBit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: if (w_csFall) w_stateNext = S_CMD;
      S_CMD: begin
        if (w_csRise)         w_stateNext = S_IDLE;
        else if (w_fieldDone) w_stateNext = S_ADDR;
      end
      S_ADDR: begin
        if (w_csRise)         w_stateNext = S_IDLE;
        else if (w_fieldDone) w_stateNext = S_DATA;
      end
      // The final data bit wins over a simultaneous deselect; done then follows from TAIL.
      S_DATA: begin
        if (w_fieldDone)      w_stateNext = S_TAIL;
        else if (w_csRise)    w_stateNext = S_IDLE;
      end
      S_TAIL: if (w_csRise || r_donePend) w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cmdValid  <= 1'b0;
      r_addrValid <= 1'b0;
      r_dataValid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_donePend  <= 1'b0;
    end else begin
      r_cmdValid  <= 1'b0;
      r_addrValid <= 1'b0;
      r_dataValid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_donePend  <= 1'b0;
      if (r_state == S_IDLE) begin
        r_bitCnt <= '0;
      end else if (w_inField && w_sampleEv) begin
        r_shift  <= w_shiftNext[SHW-2:0];
        r_bitCnt <= w_lastBit ? 7'd0 : r_bitCnt + 7'd1;
      end
      case (r_state)
        S_CMD: begin
          if (w_csRise) begin
            r_err <= 1'b1;
          end else if (w_fieldDone) begin
            r_cmd      <= w_shiftNext[CMD_BITS-1:0];
            r_cmdValid <= 1'b1;
          end
        end
        S_ADDR: begin
          if (w_csRise) begin
            r_err <= 1'b1;
          end else if (w_fieldDone) begin
            r_addr      <= w_shiftNext[ADDR_BITS-1:0];
            r_addrValid <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_fieldDone) begin
            r_data      <= w_shiftNext[DATA_BITS-1:0];
            r_dataValid <= 1'b1;
            r_donePend  <= w_csRise;
          end else if (w_csRise) begin
            r_err <= 1'b1;
          end
        end
        S_TAIL: if (w_csRise || r_donePend) r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  // Mode 0/2 must hold the first response bit through the first sample edge, so shifting
  // waits for a data bit to have been sampled; mode 1/3 presents it on the first launch edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx        <= '0;
      r_txLoaded  <= 1'b0;
      r_txStarted <= 1'b0;
    end else if (r_state != S_DATA) begin
      r_txLoaded  <= 1'b0;
      r_txStarted <= 1'b0;
    end else if (spi_sdo_valid && (r_bitCnt == 7'd0) && !w_sampleEv) begin
      r_tx        <= spi_sdo;
      r_txLoaded  <= 1'b1;
      r_txStarted <= 1'b0;
    end else if (w_launchEv && r_txLoaded) begin
      if (LATE_PHASE && !r_txStarted) begin
        r_txStarted <= 1'b1;
      end else if (LATE_PHASE || (r_bitCnt != 7'd0)) begin
        r_tx <= {r_tx[DATA_BITS-2:0], 1'b0};
      end
    end
  end

  assign spi_miso = (r_state == S_DATA) && r_txLoaded && (!LATE_PHASE || r_txStarted) &&
                    r_tx[DATA_BITS-1];

  assign spi_cmd_r        = r_cmd;
  assign spi_cmd_valid_r  = r_cmdValid;
  assign spi_addr_r       = r_addr;
  assign spi_addr_valid_r = r_addrValid;
  assign spi_data_r       = r_data;
  assign spi_data_valid_r = r_dataValid;
  assign spi_done         = r_done;
  assign spi_frame_err    = r_err;

endmodule

// File: tb/tb_spi_slave_framer.sv
// Directed bench for spi_slave_framer: a mode-0 default instance driven from a vector table
// plus corner sequences, and a mode-3 instance with alternate field sizes.
module tb_spi_slave_framer;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  logic        aSclk, aMosi, aScsn, aMiso;
  logic [15:0] aCmd;
  logic [7:0]  aAddr;
  logic [39:0] aData;
  logic [39:0] aSdo;
  logic        aSdoV, aCmdV, aAddrV, aDataV, aDone, aErr;

  logic        bSclk, bMosi, bScsn, bMiso;
  logic [7:0]  bCmd;
  logic [7:0]  bAddr;
  logic [63:0] bData;
  logic [63:0] bSdo;
  logic        bSdoV, bCmdV, bAddrV, bDataV, bDone, bErr;

  int nChecks = 0;
  int nFail = 0;
  int cyc = 0;
  int aCmdN = 0, aAddrN = 0, aDataN = 0, aDoneN = 0, aErrN = 0;
  int sCmd, sAddr, sData, sDone, sErr;
  int aDataCyc = 0, aDoneCyc = 0;
  int bCmdN = 0, bAddrN = 0, bDataN = 0, bDoneN = 0, bErrN = 0;

  typedef struct {
    logic [15:0] cmd;
    logic [7:0]  addr;
    logic [39:0] data;
    logic [39:0] sdo;
    bit          doSdo;
    logic [15:0] expCmd;
    logic [7:0]  expAddr;
    logic [39:0] expData;
    logic [39:0] expMiso;
  } vec_t;

  vec_t vecs[4];

  spi_slave_framer dutA (
    .clk(clk), .resetn(resetn), .spi_clk(aSclk), .spi_mosi(aMosi), .spi_scsn(aScsn),
    .spi_miso(aMiso), .spi_cmd_r(aCmd), .spi_cmd_valid_r(aCmdV), .spi_addr_r(aAddr),
    .spi_addr_valid_r(aAddrV), .spi_data_r(aData), .spi_data_valid_r(aDataV),
    .spi_sdo(aSdo), .spi_sdo_valid(aSdoV), .spi_done(aDone), .spi_frame_err(aErr)
  );

  spi_slave_framer #(.CMD_BYTES(1), .ADDR_BYTES(1), .DATA_BYTES(8), .CPOL(1), .CPHA(1),
                     .SYNC_STAGES(2)) dutB (
    .clk(clk), .resetn(resetn), .spi_clk(bSclk), .spi_mosi(bMosi), .spi_scsn(bScsn),
    .spi_miso(bMiso), .spi_cmd_r(bCmd), .spi_cmd_valid_r(bCmdV), .spi_addr_r(bAddr),
    .spi_addr_valid_r(bAddrV), .spi_data_r(bData), .spi_data_valid_r(bDataV),
    .spi_sdo(bSdo), .spi_sdo_valid(bSdoV), .spi_done(bDone), .spi_frame_err(bErr)
  );

  always #5 clk = ~clk;

  // Pulse counters and timestamps, sampled on the falling clk edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (aCmdV)  aCmdN++;
    if (aAddrV) aAddrN++;
    if (aDataV) begin aDataN++; aDataCyc = cyc; end
    if (aDone)  begin aDoneN++; aDoneCyc = cyc; end
    if (aErr)   aErrN++;
    if (bCmdV)  bCmdN++;
    if (bAddrV) bAddrN++;
    if (bDataV) bDataN++;
    if (bDone)  bDoneN++;
    if (bErr)   bErrN++;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic snapA();
    sCmd = aCmdN; sAddr = aAddrN; sData = aDataN; sDone = aDoneN; sErr = aErrN;
  endtask

  function automatic logic [39:0] deltaA();
    return {8'(aCmdN - sCmd), 8'(aAddrN - sAddr), 8'(aDataN - sData),
            8'(aDoneN - sDone), 8'(aErrN - sErr)};
  endfunction

  task automatic clockBitA(input logic b);
    aMosi = b;
    #100 aSclk = 1'b1;
    #100 aSclk = 1'b0;
  endtask

  // Mode-0 frame on instance A: nBits bits, optional response strobe 100 ns after addr_valid,
  // extra trailing clocks, and optionally deselect together with the last rising edge.
  task automatic applyStimulus(input logic [63:0] bits, input logic [39:0] sdo, input bit doSdo,
                               input int nBits, input int extra, input bit coinc,
                               output logic [39:0] misoCap);
    int k;
    misoCap = '0;
    @(negedge clk);
    #1 aScsn = 1'b0;
    #200;
    fork
      begin
        for (int i = 0; i < nBits; i++) begin
          aMosi = bits[63-i];
          #99;
          if (i >= 24) begin
            int idx;
            idx = 63 - i;
            misoCap[idx] = aMiso;
          end
          #1 aSclk = 1'b1;
          if (coinc && (i == nBits - 1)) aScsn = 1'b1;
          #100 aSclk = 1'b0;
        end
        for (int i = 0; i < extra; i++) clockBitA(1'b1);
      end
      begin
        if (doSdo) begin
          k = 0;
          while (!aAddrV && (k < 3000)) begin
            @(negedge clk);
            k++;
          end
          if (k >= 3000) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL sdoWait: addr_valid not seen, got 0, expected 1");
          end else begin
            #100;
            @(negedge clk);
            aSdo  = sdo;
            aSdoV = 1'b1;
            @(negedge clk);
            aSdoV = 1'b0;
          end
        end
      end
    join
    #200 aScsn = 1'b1;
    aMosi = 1'b1;
    #400;
  endtask

  task automatic applyStimulusB(input logic [79:0] bits);
    @(negedge clk);
    #1 bScsn = 1'b0;
    #200;
    for (int i = 0; i < 80; i++) begin
      bSclk = 1'b0;
      bMosi = bits[79-i];
      #100 bSclk = 1'b1;
      #100;
    end
    #200 bScsn = 1'b1;
    bMosi = 1'b1;
    #400;
  endtask

  initial begin
    logic [39:0] cap;
    logic [63:0] holdBits;

    vecs[0] = '{16'h0102, 8'h07, 40'h01234503e8, 40'h96bd30a647, 1'b1,
                16'h0102, 8'h07, 40'h01234503e8, 40'h96bd30a647};
    vecs[1] = '{16'hFFFF, 8'h80, 40'h0000000001, 40'hFFFFFFFFFF, 1'b0,
                16'hFFFF, 8'h80, 40'h0000000001, 40'h0000000000};
    vecs[2] = '{16'h8001, 8'hFF, 40'hFFFFFFFFFF, 40'h0000000001, 1'b1,
                16'h8001, 8'hFF, 40'hFFFFFFFFFF, 40'h0000000001};
    vecs[3] = '{16'h0000, 8'h00, 40'h8000000000, 40'h8000000000, 1'b1,
                16'h0000, 8'h00, 40'h8000000000, 40'h8000000000};

    aSclk = 1'b0; aMosi = 1'b1; aScsn = 1'b1; aSdo = '0; aSdoV = 1'b0;
    bSclk = 1'b1; bMosi = 1'b1; bScsn = 1'b1; bSdo = '0; bSdoV = 1'b0;
    resetn = 1'b0;
    #53;
    checkOutput("resetA pulses", {aCmdV, aAddrV, aDataV, aDone, aErr, aMiso}, 64'h0);
    checkOutput("resetA fields", {aCmd, aAddr, aData}, 64'h0);
    checkOutput("resetB pulses", {bCmdV, bAddrV, bDataV, bDone, bErr, bMiso}, 64'h0);
    checkOutput("resetB data", bData, 64'h0);
    resetn = 1'b1;
    #200;

    for (int i = 0; i < 4; i++) begin
      snapA();
      applyStimulus({vecs[i].cmd, vecs[i].addr, vecs[i].data}, vecs[i].sdo, vecs[i].doSdo,
                    64, 0, 1'b0, cap);
      checkOutput($sformatf("vec%0d cmd", i), aCmd, vecs[i].expCmd);
      checkOutput($sformatf("vec%0d addr", i), aAddr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d data", i), aData, vecs[i].expData);
      checkOutput($sformatf("vec%0d miso", i), cap, vecs[i].expMiso);
      checkOutput($sformatf("vec%0d pulses", i), deltaA(), 40'h0101010100);
      checkOutput($sformatf("vec%0d doneAfterData", i), aDoneCyc > aDataCyc, 1);
    end

    // Deselect after 20 bits: only the command completes, then one error pulse.
    snapA();
    applyStimulus({16'hABCD, 8'h5A, 40'h1122334455}, '0, 1'b0, 20, 0, 1'b0, cap);
    checkOutput("early cmd", aCmd, 16'hABCD);
    checkOutput("early addr held", aAddr, 8'h00);
    checkOutput("early data held", aData, 40'h8000000000);
    checkOutput("early pulses", deltaA(), 40'h0100000001);

    // Last data bit and deselect land in the same synchronised clk.
    snapA();
    applyStimulus({16'h1357, 8'h9B, 40'hCAFEF00D42}, '0, 1'b0, 64, 0, 1'b1, cap);
    checkOutput("coinc data", aData, 40'hCAFEF00D42);
    checkOutput("coinc pulses", deltaA(), 40'h0101010100);
    checkOutput("coinc doneNextClk", aDoneCyc == aDataCyc + 1, 1);

    // Extra clocks after the data field are ignored.
    snapA();
    applyStimulus({16'h2468, 8'h11, 40'h0F0F0F0F0F}, '0, 1'b0, 64, 8, 1'b0, cap);
    checkOutput("tail data held", aData, 40'h0F0F0F0F0F);
    checkOutput("tail pulses", deltaA(), 40'h0101010100);

    // Reset mid-frame with select held low, then a whole frame that must be ignored.
    holdBits = {16'h0102, 8'h07, 40'h01234503e8};
    @(negedge clk);
    #1 aScsn = 1'b0;
    #200;
    for (int i = 0; i < 30; i++) clockBitA(holdBits[63-i]);
    #50 resetn = 1'b0;
    #100;
    checkOutput("midReset fields cleared", {aCmd, aAddr, aData}, 64'h0);
    resetn = 1'b1;
    snapA();
    #200;
    for (int i = 0; i < 64; i++) clockBitA(holdBits[63-i]);
    #400;
    checkOutput("heldLow pulses", deltaA(), 40'h0);
    checkOutput("heldLow cmd", aCmd, 16'h0000);
    aScsn = 1'b1;
    #400;
    snapA();
    applyStimulus({16'hBEEF, 8'h42, 40'h123456789A}, '0, 1'b0, 64, 0, 1'b0, cap);
    checkOutput("rearm cmd", aCmd, 16'hBEEF);
    checkOutput("rearm addr", aAddr, 8'h42);
    checkOutput("rearm data", aData, 40'h123456789A);
    checkOutput("rearm pulses", deltaA(), 40'h0101010100);

    // Mode 3 instance with 1-byte command and 8-byte data.
    applyStimulusB({8'hA5, 8'h3C, 64'h0123456789ABCDEF});
    checkOutput("modeB cmd", bCmd, 8'hA5);
    checkOutput("modeB addr", bAddr, 8'h3C);
    checkOutput("modeB data", bData, 64'h0123456789ABCDEF);
    checkOutput("modeB pulses", {8'(bCmdN), 8'(bAddrN), 8'(bDataN), 8'(bDoneN), 8'(bErrN)},
                40'h0101010100);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/spi_slave_framer.md
SPI_SLAVE_FRAMER -- requirements
Module: spi_slave_framer

Interface
REQ-001 Parameter CMD_BYTES, default 2, command field length in bytes (1..4).
REQ-002 Parameter ADDR_BYTES, default 1, address field length in bytes (1..2).
REQ-003 Parameter DATA_BYTES, default 5, data field length in bytes (1..8).
REQ-004 Parameters CPOL, default 0, and CPHA, default 0: SPI mode select (modes 0..3).
REQ-005 Parameter SYNC_STAGES, default 2, synchroniser depth for SPI pins (2..3).
REQ-006 clk  input  1  system clock; all logic in this single domain.
REQ-007 resetn  input  1  reset, asynchronous, active-low.
REQ-008 spi_clk  input  1  SPI serial clock, asynchronous to clk.
REQ-009 spi_mosi  input  1  serial data in, MSB first.
REQ-010 spi_scsn  input  1  chip select, active-low.
REQ-011 spi_miso  output  1  serial data out, MSB first.
REQ-012 spi_cmd_r  output  CMD_BYTES*8  last complete command field.
REQ-013 spi_cmd_valid_r  output  1  one-clk pulse, command field complete.
REQ-014 spi_addr_r  output  ADDR_BYTES*8  last complete address field.
REQ-015 spi_addr_valid_r  output  1  one-clk pulse, address field complete.
REQ-016 spi_data_r  output  DATA_BYTES*8  last complete data field.
REQ-017 spi_data_valid_r  output  1  one-clk pulse, data field complete.
REQ-018 spi_sdo  input  DATA_BYTES*8  response word to shift out on MISO.
REQ-019 spi_sdo_valid  input  1  one-clk load strobe for spi_sdo.
REQ-020 spi_done  output  1  one-clk pulse, frame ended cleanly.
REQ-021 spi_frame_err  output  1  one-clk pulse, frame ended early.

Function
REQ-022 spi_clk, spi_mosi, spi_scsn SHALL pass through SYNC_STAGES flops; edges detected one flop later; sample event = synchronised sample edge (rising if CPOL==CPHA, else falling), launch event = opposite edge.
REQ-023 spi_clk high and low times SHALL be at least SYNC_STAGES+2 clk periods; shorter pulses are unsupported.
REQ-024 FSM states: IDLE, CMD, ADDR, DATA, TAIL.
REQ-025 IDLE -> CMD on synchronised scsn falling edge; bit and byte counters cleared.
REQ-026 CMD -> ADDR after CMD_BYTES*8 sample events; ADDR -> DATA after ADDR_BYTES*8; DATA -> TAIL after DATA_BYTES*8.
REQ-027 Each field SHALL shift in MSB first; on its last sample event the field register and its valid pulse update on the next clk.
REQ-028 Field registers hold value until their next completion; partial fields never update them.
REQ-029 Sample events in TAIL are ignored; no register changes.
REQ-030 spi_sdo_valid SHALL load the TX shift register only in DATA before the first data sample event; otherwise ignored.
REQ-031 CPHA=0: spi_miso presents TX MSB the clk after load; shift on each launch event. CPHA=1: shift on launch events, first bit at first launch event after load.
REQ-032 spi_miso SHALL be 0 in IDLE, CMD, ADDR, TAIL, and in DATA when no load occurred.
REQ-033 Synchronised scsn rising edge in TAIL: spi_done pulses one clk, FSM -> IDLE.
REQ-034 Synchronised scsn rising edge in CMD, ADDR or DATA: spi_frame_err pulses one clk, FSM -> IDLE, no further valid pulses.
REQ-035 Completion of the final data bit coincident with scsn rising edge SHALL yield spi_data_valid_r then spi_done on the following clk; no frame_err.
REQ-036 Valid, done and err pulses are mutually exclusive per clk except as in REQ-035 ordering.

Reset
REQ-037 resetn low SHALL immediately clear all flops: outputs 0, spi_miso 0, FSM IDLE, synchronisers to idle levels (scsn 1, spi_clk CPOL, mosi 1).
REQ-038 After resetn release with spi_scsn already low, the block SHALL stay IDLE until scsn is seen high then low.
REQ-039 Reset mid-frame SHALL produce no valid, done or err pulse.

Verification
REQ-040 Mode 0, defaults, clk 100 MHz, spi half-period 100 ns: cmd 16'h0102, addr 8'h07, data 40'h01234503e8 -> cmd_valid with 0x0102, addr_valid with 0x07, data_valid with 0x01234503e8, then spi_done.
REQ-041 Same frame, spi_sdo=40'h96bd30a647 strobed 100 ns after addr_valid -> MISO bitstream during data equals 0x96bd30a647.
REQ-042 scsn raised after 20 bits -> cmd_valid only, spi_frame_err one pulse, addr/data registers unchanged.
REQ-043 CPOL=1, CPHA=1, CMD_BYTES=1, DATA_BYTES=8: cmd 8'hA5, addr 8'h3C, data 64'h0123456789ABCDEF -> all fields correct, spi_done.
REQ-044 resetn pulsed low at bit 30, scsn held low, new frame without raising scsn -> no pulses; after scsn high-low, valid frame decoded normally.
REQ-045 Eight extra spi_clk cycles after data field -> no extra pulses, spi_done on scsn high, spi_data_r unchanged.
